gcd_req_ctrl: RTL and testbench

//  Initiator side of the GCD engine handshake. Accepts operand pairs on a valid/ready

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_req_timer.sv | 30 +++
 rtl/gcd_req_ctrl.sv | 138 +++++++++++++
 tb/tb_gcd_req_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD request controller.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RESP    = 2'd3
    } gcd_req_state_e;

    localparam int GCD_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/gcd_req_timer.sv
// Timeout counter shared by the ISSUE and RELEASE waits: clear, count up, flag the last cycle.
module gcd_req_timer
    import gcd_pkg::*;
#(
    parameter int TIMEOUT_CYC = GCD_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic nreset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/gcd_req_ctrl.sv
// Initiator for the GCD engine: request handshake in, enable/done to the engine,
// response handshake out, zero-operand bypass and engine timeout.
module gcd_req_ctrl
    import gcd_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = GCD_TIMEOUT_DEFAULT,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_a_i,
    input  logic [DATA_WIDTH-1:0] req_b_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_gcd_o,
    output logic                  rsp_err_o,
    output logic [DATA_WIDTH-1:0] operand_a_o,
    output logic [DATA_WIDTH-1:0] operand_b_o,
    output logic                  gcd_enable_o,
    input  logic [DATA_WIDTH-1:0] gcd_i,
    input  logic                  gcd_done_i,
    output logic [CNT_WIDTH-1:0]  done_cnt_o
);

    gcd_req_state_e state;
    logic           timer_clear;
    logic           timer_inc;
    logic           timer_expired;

    gcd_req_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk_i),
        .nreset (nreset_i),
        .clear  (timer_clear),
        .inc    (timer_inc),
        .expired(timer_expired)
    );

    // The timer restarts whenever a wait ends, so RELEASE always starts from zero.
    always_comb begin
        timer_clear = 1'b1;
        timer_inc   = 1'b0;
        case (state)
            ST_ISSUE: begin
                if (!gcd_done_i && !timer_expired) begin
                    timer_clear = 1'b0;
                    timer_inc   = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (gcd_done_i && !timer_expired) begin
                    timer_clear = 1'b0;
                    timer_inc   = 1'b1;
                end
            end
            default: begin
                timer_clear = 1'b1;
                timer_inc   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state        <= ST_IDLE;
            req_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_gcd_o    <= '0;
            rsp_err_o    <= 1'b0;
            operand_a_o  <= '0;
            operand_b_o  <= '0;
            gcd_enable_o <= 1'b0;
            done_cnt_o   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        if (req_a_i == '0 || req_b_i == '0) begin
                            // gcd(x,0) = x and gcd(0,0) = 0, so the OR is the answer.
                            rsp_gcd_o   <= req_a_i | req_b_i;
                            rsp_err_o   <= 1'b0;
                            rsp_valid_o <= 1'b1;
                            state       <= ST_RESP;
                        end else begin
                            operand_a_o  <= req_a_i;
                            operand_b_o  <= req_b_i;
                            gcd_enable_o <= 1'b1;
                            state        <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (gcd_done_i) begin
                        rsp_gcd_o    <= gcd_i;
                        rsp_err_o    <= 1'b0;
                        gcd_enable_o <= 1'b0;
                        state        <= ST_RELEASE;
                    end else if (timer_expired) begin
                        rsp_gcd_o    <= '0;
                        rsp_err_o    <= 1'b1;
                        gcd_enable_o <= 1'b0;
                        state        <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Hold off the response until done has returned to zero.
                    if (!gcd_done_i) begin
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                    end else if (timer_expired) begin
                        rsp_gcd_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        done_cnt_o  <= done_cnt_o + 1'b1;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_req_ctrl.sv
// Bench for gcd_req_ctrl with a behavioural GCD engine model and a Euclid reference.
module tb_gcd_req_ctrl;

    localparam int DW = 8;
    localparam int TO = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready_o;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic          rsp_valid_o;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_gcd_o;
    logic          rsp_err_o;
    logic [DW-1:0] operand_a_o;
    logic [DW-1:0] operand_b_o;
    logic          gcd_enable_o;
    logic [DW-1:0] eng_gcd;
    logic          eng_done;
    logic [CW-1:0] done_cnt_o;

    int tests_run = 0;
    int tests_failed = 0;
    logic [CW-1:0] exp_cnt = '0;

    int eng_mode = 0;   // 0 normal, 1 never done, 2 done stuck high
    int eng_lat = 2;

    always #5 clk = ~clk;

    gcd_req_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYC(TO), .CNT_WIDTH(CW)) dut (
        .clk_i       (clk),
        .nreset_i    (nreset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_gcd_o   (rsp_gcd_o),
        .rsp_err_o   (rsp_err_o),
        .operand_a_o (operand_a_o),
        .operand_b_o (operand_b_o),
        .gcd_enable_o(gcd_enable_o),
        .gcd_i       (eng_gcd),
        .gcd_done_i  (eng_done),
        .done_cnt_o  (done_cnt_o)
    );

    function automatic logic [DW-1:0] sub_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] x, y;
        x = a; y = b;
        if (x == 0) return y;
        if (y == 0) return x;
        while (x != y) begin
            if (x > y) x = x - y;
            else y = y - x;
        end
        return x;
    endfunction

    function automatic int ref_gcd(input int a, input int b);
        int x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    // Engine model: enable through a 2-flop sync, done after a programmable latency.
    logic en_s1, en_s2;
    int   lat_cnt;
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            en_s1 <= 1'b0; en_s2 <= 1'b0; eng_done <= 1'b0; eng_gcd <= '0; lat_cnt <= 0;
        end else begin
            en_s1 <= gcd_enable_o;
            en_s2 <= en_s1;
            if (eng_mode == 1) begin
                eng_done <= 1'b0; lat_cnt <= 0;
            end else if (eng_mode == 2) begin
                if (en_s2) begin
                    eng_done <= 1'b1; eng_gcd <= sub_gcd(operand_a_o, operand_b_o);
                end
            end else if (en_s2 && !eng_done) begin
                if (lat_cnt >= eng_lat) begin
                    eng_done <= 1'b1; eng_gcd <= sub_gcd(operand_a_o, operand_b_o);
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end else if (!en_s2) begin
                eng_done <= 1'b0; lat_cnt <= 0;
            end
        end
    end

    logic en_prev = 1'b0;
    int   en_rises = 0;
    int   en_cycles = 0;
    always @(posedge clk) begin
        en_prev <= gcd_enable_o;
        if (gcd_enable_o && !en_prev) en_rises <= en_rises + 1;
        if (gcd_enable_o) en_cycles <= en_cycles + 1;
    end

    task automatic drive_req(input logic [DW-1:0] a, input logic [DW-1:0] b, output bit ok);
        ok = 1'b0;
        req_a = a; req_b = b; req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (req_ready_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (rsp_valid_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 0", req_ready_o); end
        tests_run++; if (rsp_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
        tests_run++; if (gcd_enable_o !== 1'b0) begin tests_failed++; $display("FAIL reset_enable: got %b expected 0", gcd_enable_o); end
        tests_run++; if (done_cnt_o !== '0) begin tests_failed++; $display("FAIL reset_done_cnt: got %0d expected 0", done_cnt_o); end
        tests_run++; if ({rsp_gcd_o, rsp_err_o, operand_a_o, operand_b_o} !== '0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", {rsp_gcd_o, rsp_err_o, operand_a_o, operand_b_o}); end
        nreset = 1'b1;
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        tests_run++; if (req_ready_o !== 1'b1) begin tests_failed++; $display("FAIL idle_req_ready: got %b expected 1", req_ready_o); end
    endtask

    task automatic test_basic();
        bit ok; int r0;
        eng_mode = 0; eng_lat = 2;
        r0 = en_rises;
        drive_req(8'd48, 8'd18, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL basic_accept: got no accept expected accept"); end
        wait_rsp(100, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL basic_rsp_timeout: got no rsp_valid expected rsp_valid"); end
        tests_run++; if (rsp_gcd_o !== 8'd6 || rsp_err_o !== 1'b0) begin tests_failed++; $display("FAIL basic_result: got gcd=%0d err=%b expected gcd=6 err=0", rsp_gcd_o, rsp_err_o); end
        tests_run++; if (en_rises - r0 !== 1) begin tests_failed++; $display("FAIL basic_enable_pulses: got %0d expected 1", en_rises - r0); end
        consume_rsp();
        tests_run++; if (done_cnt_o !== exp_cnt) begin tests_failed++; $display("FAIL basic_done_cnt: got %0d expected %0d", done_cnt_o, exp_cnt); end
    endtask

    task automatic test_zero_bypass();
        bit ok; int r0;
        logic [DW-1:0] za [3] = '{8'd0, 8'd0, 8'd77};
        logic [DW-1:0] zb [3] = '{8'd35, 8'd0, 8'd0};
        for (int k = 0; k < 3; k++) begin
            r0 = en_rises;
            drive_req(za[k], zb[k], ok);
            tests_run++; if (rsp_valid_o !== 1'b1) begin tests_failed++; $display("FAIL zero_latency[%0d]: got rsp_valid=%b expected 1", k, rsp_valid_o); end
            tests_run++; if (rsp_gcd_o !== 8'(ref_gcd(za[k], zb[k])) || rsp_err_o !== 1'b0) begin tests_failed++; $display("FAIL zero_result[%0d]: got gcd=%0d err=%b expected gcd=%0d err=0", k, rsp_gcd_o, rsp_err_o, ref_gcd(za[k], zb[k])); end
            consume_rsp();
            tests_run++; if (en_rises - r0 !== 0) begin tests_failed++; $display("FAIL zero_no_enable[%0d]: got %0d pulses expected 0", k, en_rises - r0); end
            tests_run++; if (done_cnt_o !== exp_cnt) begin tests_failed++; $display("FAIL zero_done_cnt[%0d]: got %0d expected %0d", k, done_cnt_o, exp_cnt); end
        end
    endtask

    task automatic test_timeout();
        bit ok; int c0;
        eng_mode = 1;
        drive_req(8'd40, 8'd24, ok);
        c0 = en_cycles;
        wait_rsp(100, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL timeout_rsp: got no rsp_valid expected rsp_valid"); end
        tests_run++; if (rsp_gcd_o !== 8'd0 || rsp_err_o !== 1'b1) begin tests_failed++; $display("FAIL timeout_result: got gcd=%0d err=%b expected gcd=0 err=1", rsp_gcd_o, rsp_err_o); end
        tests_run++; if (en_cycles - c0 !== TO) begin tests_failed++; $display("FAIL timeout_enable_len: got %0d expected %0d", en_cycles - c0, TO); end
        consume_rsp();
        // Engine raises done but never drops it: RELEASE has to give up.
        eng_mode = 2;
        drive_req(8'd40, 8'd24, ok);
        wait_rsp(100, ok);
        tests_run++; if (!ok || rsp_gcd_o !== 8'd0 || rsp_err_o !== 1'b1) begin tests_failed++; $display("FAIL release_timeout: got valid=%b gcd=%0d err=%b expected valid=1 gcd=0 err=1", rsp_valid_o, rsp_gcd_o, rsp_err_o); end
        eng_mode = 0;
        consume_rsp();
        repeat (4) @(negedge clk);
        tests_run++; if (done_cnt_o !== exp_cnt) begin tests_failed++; $display("FAIL timeout_done_cnt: got %0d expected %0d", done_cnt_o, exp_cnt); end
    endtask

    task automatic test_done_timeout_tie();
        bit ok;
        // Latency 12 lands done exactly on the last ISSUE cycle; 13 lands one cycle late.
        eng_mode = 0; eng_lat = 12;
        drive_req(8'd56, 8'd24, ok);
        wait_rsp(100, ok);
        tests_run++; if (!ok || rsp_gcd_o !== 8'd8 || rsp_err_o !== 1'b0) begin tests_failed++; $display("FAIL tie_done_wins: got valid=%b gcd=%0d err=%b expected valid=1 gcd=8 err=0", rsp_valid_o, rsp_gcd_o, rsp_err_o); end
        consume_rsp();
        eng_lat = 13;
        drive_req(8'd56, 8'd24, ok);
        wait_rsp(100, ok);
        tests_run++; if (!ok || rsp_gcd_o !== 8'd0 || rsp_err_o !== 1'b1) begin tests_failed++; $display("FAIL late_done_timeout: got valid=%b gcd=%0d err=%b expected valid=1 gcd=0 err=1", rsp_valid_o, rsp_gcd_o, rsp_err_o); end
        consume_rsp();
        eng_lat = 2;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        eng_mode = 0; eng_lat = 1;
        drive_req(8'd84, 8'd36, ok);
        wait_rsp(100, ok);
        for (int i = 0; i < 10; i++) begin
            tests_run++; if (rsp_valid_o !== 1'b1 || rsp_gcd_o !== 8'd12 || req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL backpressure_hold[%0d]: got valid=%b gcd=%0d req_ready=%b expected valid=1 gcd=12 req_ready=0", i, rsp_valid_o, rsp_gcd_o, req_ready_o); end
            @(negedge clk);
        end
        consume_rsp();
        tests_run++; if (rsp_valid_o !== 1'b0 || done_cnt_o !== exp_cnt) begin tests_failed++; $display("FAIL backpressure_handshake: got valid=%b cnt=%0d expected valid=0 cnt=%0d", rsp_valid_o, done_cnt_o, exp_cnt); end
        @(negedge clk);
        tests_run++; if (done_cnt_o !== exp_cnt) begin tests_failed++; $display("FAIL backpressure_single: got cnt=%0d expected %0d", done_cnt_o, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [DW-1:0] ba [3] = '{8'd255, 8'd100, 8'd13};
        logic [DW-1:0] bb [3] = '{8'd17, 8'd75, 8'd13};
        logic [CW-1:0] c0;
        c0 = exp_cnt;
        eng_mode = 0; eng_lat = 0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_req(ba[k], bb[k], ok);
            wait_rsp(100, ok);
            tests_run++; if (!ok || rsp_gcd_o !== 8'(ref_gcd(ba[k], bb[k]))) begin tests_failed++; $display("FAIL b2b_result[%0d]: got valid=%b gcd=%0d expected gcd=%0d", k, rsp_valid_o, rsp_gcd_o, ref_gcd(ba[k], bb[k])); end
            @(negedge clk);
            exp_cnt = exp_cnt + 1'b1;
            tests_run++; if (req_ready_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_next[%0d]: got %b expected 1", k, req_ready_o); end
        end
        rsp_ready = 1'b0;
        tests_run++; if (done_cnt_o !== c0 + 3'd3) begin tests_failed++; $display("FAIL b2b_done_cnt: got %0d expected %0d", done_cnt_o, c0 + 3'd3); end
        eng_lat = 2;
    endtask

    task automatic test_reset_mid();
        bit ok;
        eng_mode = 1;
        drive_req(8'd30, 8'd12, ok);
        repeat (3) @(negedge clk);
        tests_run++; if (gcd_enable_o !== 1'b1) begin tests_failed++; $display("FAIL midreset_in_issue: got enable=%b expected 1", gcd_enable_o); end
        nreset = 1'b0;
        #1;
        tests_run++; if (gcd_enable_o !== 1'b0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL midreset_outputs: got en=%b valid=%b ready=%b expected 0 0 0", gcd_enable_o, rsp_valid_o, req_ready_o); end
        tests_run++; if (done_cnt_o !== '0 || operand_a_o !== '0) begin tests_failed++; $display("FAIL midreset_state: got cnt=%0d opa=%0d expected 0 0", done_cnt_o, operand_a_o); end
        exp_cnt = '0;
        @(negedge clk);
        nreset = 1'b1;
        eng_mode = 0;
        repeat (2) @(negedge clk);
        drive_req(8'd30, 8'd12, ok);
        wait_rsp(100, ok);
        tests_run++; if (!ok || rsp_gcd_o !== 8'd6 || rsp_err_o !== 1'b0) begin tests_failed++; $display("FAIL midreset_recover: got valid=%b gcd=%0d err=%b expected valid=1 gcd=6 err=0", rsp_valid_o, rsp_gcd_o, rsp_err_o); end
        consume_rsp();
        tests_run++; if (done_cnt_o !== 16'd1) begin tests_failed++; $display("FAIL midreset_done_cnt: got %0d expected 1", done_cnt_o); end
    endtask

    task automatic test_random();
        bit ok; int r0;
        logic [DW-1:0] a, b;
        eng_mode = 0;
        for (int k = 0; k < 40; k++) begin
            a = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            eng_lat = $urandom_range(0, 6);
            r0 = en_rises;
            drive_req(a, b, ok);
            if (a == 0 || b == 0) begin
                tests_run++; if (rsp_valid_o !== 1'b1) begin tests_failed++; $display("FAIL rand_zero_latency[%0d]: got valid=%b expected 1", k, rsp_valid_o); end
            end
            wait_rsp(100, ok);
            tests_run++; if (!ok || rsp_gcd_o !== 8'(ref_gcd(a, b)) || rsp_err_o !== 1'b0) begin tests_failed++; $display("FAIL rand_result[%0d]: a=%0d b=%0d got gcd=%0d err=%b expected gcd=%0d err=0", k, a, b, rsp_gcd_o, rsp_err_o, ref_gcd(a, b)); end
            tests_run++; if (en_rises - r0 !== ((a == 0 || b == 0) ? 0 : 1)) begin tests_failed++; $display("FAIL rand_enable[%0d]: got %0d pulses expected %0d", k, en_rises - r0, (a == 0 || b == 0) ? 0 : 1); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            consume_rsp();
            tests_run++; if (done_cnt_o !== exp_cnt) begin tests_failed++; $display("FAIL rand_done_cnt[%0d]: got %0d expected %0d", k, done_cnt_o, exp_cnt); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_bypass();
        test_timeout();
        test_done_timeout_tie();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
